// File: rtl/segment_chaser_multi.sv
`default_nettype none
// ============================================================================
// Module   : segment_chaser_multi
// Purpose  : Multi-digit 7-segment chaser with SYNC / PERIMETER / CASCADE
//            rings, direction, hold, prescaled auto-step and wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module segment_chaser_multi #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_W      = 16,
    localparam int POS_W     = $clog2(6 * NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    async_nreset,
    input  logic                    step_re,
    input  logic                    auto_en,
    input  logic [DIV_W-1:0]        period,
    input  logic                    dir,
    input  logic                    hold,
    input  logic [1:0]              mode,
    output logic [8*NUM_DIGITS-1:0] display,
    output logic [POS_W-1:0]        pos,
    output logic                    wrap
);

    localparam logic [1:0] c_mode_sync      = 2'd0;
    localparam logic [1:0] c_mode_perimeter = 2'd1;
    localparam logic [1:0] c_mode_cascade   = 2'd2;

    logic [1:0]       r_mode;
    logic [POS_W-1:0] r_pos;
    logic [DIV_W-1:0] r_presc;
    logic             r_wrap;

    logic [POS_W-1:0] w_last;
    logic             w_tick;
    logic             w_step;
    logic [7:0]       w_sync_seg;
    logic [7:0]       w_casc_seg;
    logic [POS_W-1:0] w_casc_digit;

    // Last valid ring position for the active geometry; mode 3 behaves as SYNC.
    always_comb begin
        w_last = POS_W'(5);
        case (r_mode)
            c_mode_perimeter: w_last = POS_W'(2 * NUM_DIGITS + 3);
            c_mode_cascade:   w_last = POS_W'(6 * NUM_DIGITS - 1);
            default:          w_last = POS_W'(5);
        endcase
    end

    assign w_tick = auto_en & ~hold & (r_presc == period);
    assign w_step = (step_re | w_tick) & ~hold;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            r_mode  <= c_mode_sync;
            r_pos   <= '0;
            r_presc <= '0;
            r_wrap  <= 1'b0;
        end else if (mode != r_mode) begin
            // A geometry change restarts the ring and outranks any pending step.
            r_mode  <= mode;
            r_pos   <= '0;
            r_presc <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;

            if (!auto_en) begin
                r_presc <= '0;
            end else if (!hold) begin
                r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
            end

            if (w_step) begin
                if (!dir) begin
                    if (r_pos == w_last) begin
                        r_pos  <= '0;
                        r_wrap <= 1'b1;
                    end else begin
                        r_pos <= r_pos + POS_W'(1);
                    end
                end else begin
                    if (r_pos == '0) begin
                        r_pos  <= w_last;
                        r_wrap <= 1'b1;
                    end else begin
                        r_pos <= r_pos - POS_W'(1);
                    end
                end
            end
        end
    end

    assign w_sync_seg   = 8'h01 << r_pos;
    assign w_casc_digit = r_pos / POS_W'(6);
    assign w_casc_seg   = 8'h01 << (r_pos % POS_W'(6));

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        logic [7:0] w_seg;

        // Perimeter runs clockwise: top row left-to-right, right edge down,
        // bottom row right-to-left, left edge up.
        always_comb begin
            w_seg = 8'h00;
            case (r_mode)
                c_mode_perimeter: begin
                    if (r_pos == POS_W'(k)) begin
                        w_seg = 8'h01;
                    end else if (k == NUM_DIGITS - 1 && r_pos == POS_W'(NUM_DIGITS)) begin
                        w_seg = 8'h02;
                    end else if (k == NUM_DIGITS - 1 && r_pos == POS_W'(NUM_DIGITS + 1)) begin
                        w_seg = 8'h04;
                    end else if (r_pos == POS_W'(2 * NUM_DIGITS + 1 - k)) begin
                        w_seg = 8'h08;
                    end else if (k == 0 && r_pos == POS_W'(2 * NUM_DIGITS + 2)) begin
                        w_seg = 8'h10;
                    end else if (k == 0 && r_pos == POS_W'(2 * NUM_DIGITS + 3)) begin
                        w_seg = 8'h20;
                    end
                end
                c_mode_cascade: begin
                    if (w_casc_digit == POS_W'(k)) begin
                        w_seg = w_casc_seg;
                    end
                end
                default: w_seg = w_sync_seg;
            endcase
        end

        assign display[8*k +: 8] = w_seg;
    end

    assign pos  = r_pos;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_segment_chaser_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_segment_chaser_multi
// Purpose  : Directed self-checking bench for segment_chaser_multi (N=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_segment_chaser_multi;

    logic        clk;
    logic        async_nreset;
    logic        step_re;
    logic        auto_en;
    logic [15:0] period;
    logic        dir;
    logic        hold;
    logic [1:0]  mode;
    logic [31:0] display;
    logic [4:0]  pos;
    logic        wrap;

    int n_checks = 0;
    int n_pass   = 0;

    segment_chaser_multi #(.NUM_DIGITS(4), .DIV_W(16)) dut (
        .clk          (clk),
        .async_nreset (async_nreset),
        .step_re      (step_re),
        .auto_en      (auto_en),
        .period       (period),
        .dir          (dir),
        .hold         (hold),
        .mode         (mode),
        .display      (display),
        .pos          (pos),
        .wrap         (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic do_step;
        step_re = 1'b1;
        @(negedge clk);
        step_re = 1'b0;
    endtask

    logic [31:0] perim_exp [12];
    logic [7:0]  seg;

    initial begin
        perim_exp = '{32'h00000100, 32'h00010000, 32'h01000000, 32'h02000000,
                      32'h04000000, 32'h08000000, 32'h00080000, 32'h00000800,
                      32'h00000008, 32'h00000010, 32'h00000020, 32'h00000001};

        async_nreset = 1'b0;
        step_re = 1'b0; auto_en = 1'b0; period = 16'd0;
        dir = 1'b0; hold = 1'b0; mode = 2'd0;
        #12;
        check("rst_display", 64'(display), 64'h01010101);
        check("rst_pos", 64'(pos), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        @(negedge clk);
        async_nreset = 1'b1;
        @(negedge clk);

        // SYNC ring of six
        for (int i = 0; i < 6; i++) begin
            do_step;
            seg = 8'h01 << ((i + 1) % 6);
            check("sync_display", 64'(display), 64'({4{seg}}));
            check("sync_wrap", 64'(wrap), 64'(i == 5));
        end
        @(negedge clk);
        check("sync_wrap_clear", 64'(wrap), 64'd0);

        // PERIMETER ring of twelve
        mode = 2'd1;
        @(negedge clk);
        check("perim_start_pos", 64'(pos), 64'd0);
        check("perim_start_disp", 64'(display), 64'h00000001);
        for (int i = 0; i < 12; i++) begin
            do_step;
            check("perim_display", 64'(display), 64'(perim_exp[i]));
            check("perim_pos", 64'(pos), 64'((i + 1) % 12));
            check("perim_wrap", 64'(wrap), 64'(i == 11));
        end

        // CASCADE reverse from 0
        mode = 2'd2; dir = 1'b1;
        @(negedge clk);
        check("casc_start_disp", 64'(display), 64'h00000001);
        do_step;
        check("casc_rev_pos", 64'(pos), 64'd23);
        check("casc_rev_disp", 64'(display), 64'h20000000);
        check("casc_rev_wrap", 64'(wrap), 64'd1);
        do_step;
        check("casc_rev2_pos", 64'(pos), 64'd22);
        check("casc_rev2_disp", 64'(display), 64'h10000000);
        check("casc_rev2_wrap", 64'(wrap), 64'd0);

        // Auto-step every four cycles
        dir = 1'b0; period = 16'd3; auto_en = 1'b1;
        repeat (3) @(negedge clk);
        check("auto_before_tick", 64'(pos), 64'd22);
        @(negedge clk);
        check("auto_tick1", 64'(pos), 64'd23);
        repeat (4) @(negedge clk);
        check("auto_tick2", 64'(pos), 64'd0);
        check("auto_wrap", 64'(wrap), 64'd1);
        repeat (3) @(negedge clk);
        do_step;
        check("auto_coincident", 64'(pos), 64'd1);

        // Hold with prescaler parked at 2
        repeat (2) @(negedge clk);
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step_re = (i == 4);
            @(negedge clk);
        end
        step_re = 1'b0;
        check("hold_pos", 64'(pos), 64'd1);
        check("hold_wrap", 64'(wrap), 64'd0);
        hold = 1'b0;
        @(negedge clk);
        check("resume_pos_a", 64'(pos), 64'd1);
        @(negedge clk);
        check("resume_pos_b", 64'(pos), 64'd2);
        auto_en = 1'b0;
        @(negedge clk);

        // Mode change outranks a simultaneous step
        for (int i = 0; i < 15; i++) do_step;
        check("casc_pos17", 64'(pos), 64'd17);
        check("casc_disp17", 64'(display), 64'h00200000);
        mode = 2'd1;
        do_step;
        check("modechg_pos", 64'(pos), 64'd0);
        check("modechg_disp", 64'(display), 64'h00000001);
        check("modechg_wrap", 64'(wrap), 64'd0);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 9; i++) do_step;
        check("pre_rst_pos", 64'(pos), 64'd9);
        check("pre_rst_disp", 64'(display), 64'h00000008);
        #2 async_nreset = 1'b0;
        #1;
        check("async_rst_pos", 64'(pos), 64'd0);
        check("async_rst_disp", 64'(display), 64'h01010101);
        @(negedge clk);
        async_nreset = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
